// File: rtl/key_expand_seq.sv
// AES-128 key expansion, one round key per clock.
// A start in IDLE or DONE captures the cipher key into slot 0 and clears the
// remaining slots. RUN then fills slots 1..10 in order, each one derived from
// the slot before it. DONE holds the full 44-word schedule until the next start.
module key_expand_seq (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [127:0]  key,
    output logic [1407:0] word,
    output logic          busy,
    output logic          valid
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // FIPS-197 S-box. Entry 0x00 is the most significant byte.
    localparam logic [2047:0] SBOX_TBL = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] x);
        return SBOX_TBL[2047 - 8 * int'(x) -: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    // GF(2^8) doubling, giving the round-constant sequence 01,02,...,80,1b,36.
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    state_t          state_q, state_d;
    logic [1407:0]   word_q, word_d;
    logic [3:0]      round_q, round_d;
    logic [7:0]      rcon_q, rcon_d;

    logic [127:0]    prev_rk;
    logic [127:0]    next_rk;
    logic [31:0]     temp;

    // Pick round key (round_q - 1) out of the schedule register.
    always_comb begin
        prev_rk = word_q[1407 -: 128];
        for (int s = 1; s <= 10; s++) begin
            if (round_q == 4'(s)) begin
                prev_rk = word_q[1407 - 128 * (s - 1) -: 128];
            end
        end
    end

    // One round of the key schedule: RotWord, SubWord, rcon, then the XOR chain.
    always_comb begin
        temp = sub_word({prev_rk[23:0], prev_rk[31:24]}) ^ {rcon_q, 24'h000000};
        next_rk[127:96] = prev_rk[127:96] ^ temp;
        next_rk[95:64]  = prev_rk[95:64]  ^ next_rk[127:96];
        next_rk[63:32]  = prev_rk[63:32]  ^ next_rk[95:64];
        next_rk[31:0]   = prev_rk[31:0]   ^ next_rk[63:32];
    end

    // Next-state logic: load on start, fill one slot per RUN cycle, hold otherwise.
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        round_d = round_q;
        rcon_d  = rcon_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    word_d  = {key, 1280'd0};
                    rcon_d  = 8'h01;
                    round_d = 4'd1;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int s = 1; s <= 10; s++) begin
                    if (round_q == 4'(s)) begin
                        word_d[1407 - 128 * s -: 128] = next_rk;
                    end
                end
                rcon_d = xtime(rcon_q);
                if (round_q == 4'd10) begin
                    state_d = DONE;
                end else begin
                    round_d = round_q + 4'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset clears the schedule so no partial result survives.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            round_q <= 4'd0;
            rcon_q  <= 8'h01;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            round_q <= round_d;
            rcon_q  <= rcon_d;
        end
    end

    assign word  = word_q;
    assign busy  = (state_q == RUN);
    assign valid = (state_q == DONE);

endmodule
